// File: rtl/bin2bcd_seq_pkg.sv
// Shared definitions for the iterative binary-to-BCD converter.
package bin2bcd_seq_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    CONV = 1'b1
  } state_t;

  localparam int unsigned SCR_DIGITS     = 10;
  localparam int unsigned SCR_W          = 4 * SCR_DIGITS;
  localparam int unsigned BCD_ADJ_THRESH = 5;
  localparam int unsigned BCD_ADJ_ADD    = 3;
  localparam int unsigned CNT_W          = 6;

endpackage

// File: rtl/bcd_digit_adj.sv
// Double-dabble digit correction: digits of 5 or more get +3 before the shift.
module bcd_digit_adj
  import bin2bcd_seq_pkg::*;
(
  input  logic [3:0] d,
  output logic [3:0] adj_c
);

  assign adj_c = (d >= 4'(BCD_ADJ_THRESH)) ? d + 4'(BCD_ADJ_ADD) : d;

endmodule

// File: rtl/bin2bcd_seq.sv
// Iterative shift-add-3 converter: one bit per clock, result held between conversions.
module bin2bcd_seq
  import bin2bcd_seq_pkg::*;
#(
  parameter int unsigned BIN_W      = 32,
  parameter int unsigned OUT_DIGITS = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [BIN_W-1:0]        bin,
  output logic                    busy,
  output logic                    done,
  output logic [4*OUT_DIGITS-1:0] bcd,
  output logic                    overflow
);

  localparam int unsigned OUT_W = 4 * OUT_DIGITS;
  localparam int unsigned CAT_W = SCR_W + BIN_W;

  state_t             state;
  state_t             state_next;
  logic [BIN_W-1:0]   bin_sr;
  logic [SCR_W-1:0]   scr;
  logic [SCR_W-1:0]   scr_adj;
  logic [CAT_W-1:0]   cat_shift;
  logic [SCR_W-1:0]   scr_shift;
  logic [BIN_W-1:0]   bin_shift;
  logic [CNT_W-1:0]   cnt;
  logic               load;
  logic               step;
  logic               last;

  // Per-digit correction of the scratch register ahead of each shift.
  for (genvar g = 0; g < SCR_DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .d     (scr[4*g +: 4]),
      .adj_c (scr_adj[4*g +: 4])
    );
  end

  assign cat_shift = {scr_adj, bin_sr} << 1;
  assign scr_shift = cat_shift[CAT_W-1:BIN_W];
  assign bin_shift = cat_shift[BIN_W-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next state and datapath controls.
  always_comb begin
    state_next = state;
    load       = 1'b0;
    step       = 1'b0;
    last       = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load       = 1'b1;
          state_next = CONV;
        end
      end
      CONV: begin
        step = 1'b1;
        if (cnt == CNT_W'(BIN_W - 1)) begin
          last       = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Shift registers, iteration counter and held outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bin_sr   <= '0;
      scr      <= '0;
      cnt      <= '0;
      done     <= 1'b0;
      bcd      <= '0;
      overflow <= 1'b0;
    end else begin
      done <= last;
      if (load) begin
        bin_sr <= bin;
        scr    <= '0;
        cnt    <= '0;
      end else if (step) begin
        bin_sr <= bin_shift;
        scr    <= scr_shift;
        cnt    <= cnt + CNT_W'(1);
      end
      if (last) begin
        bcd      <= scr_shift[OUT_W-1:0];
        overflow <= |(scr_shift >> OUT_W);
      end
    end
  end

  assign busy = (state == CONV);

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Self-checking bench for bin2bcd_seq: vector table, random values vs. decimal model, corner sequences.
module tb_bin2bcd_seq;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [31:0] bin;
  logic        busy;
  logic        done;
  logic [31:0] bcd;
  logic        overflow;

  int n_checks = 0;
  int n_fail   = 0;

  bin2bcd_seq #(.BIN_W(32), .OUT_DIGITS(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .bin      (bin),
    .busy     (busy),
    .done     (done),
    .bcd      (bcd),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] v;
    logic [31:0] exp_bcd;
    logic        exp_ovf;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Decimal model: value mod 10^8 as packed digits by repeated division.
  function automatic logic [31:0] model_bcd(input longint unsigned v);
    longint unsigned r;
    logic [31:0]     b;
    r = v % 64'd100000000;
    b = '0;
    for (int i = 0; i < 8; i++) begin
      b[4*i +: 4] = 4'(r % 10);
      r = r / 10;
    end
    return b;
  endfunction

  // One full conversion, checking latency, busy window, single done and held output.
  task automatic run_conv(input logic [31:0] v, input string tag,
                          input logic [31:0] exp_bcd, input logic exp_ovf);
    int          lat;
    int          busy_cnt;
    int          ndone;
    logic        hold_bad;
    logic [31:0] prev_bcd;
    logic        prev_ovf;
    @(negedge clk);
    bin   = v;
    start = 1'b1;
    prev_bcd = bcd;
    prev_ovf = overflow;
    @(posedge clk);
    #1;
    start    = 1'b0;
    bin      = $urandom;
    busy_cnt = busy ? 1 : 0;
    lat      = -1;
    ndone    = 0;
    hold_bad = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      #1;
      if (busy) busy_cnt++;
      if (done) begin
        ndone++;
        if (lat < 0) lat = k;
      end else if (lat < 0 && (bcd !== prev_bcd || overflow !== prev_ovf)) begin
        hold_bad = 1'b1;
      end
    end
    check({tag, "_latency"}, 64'(lat), 64'd32);
    check({tag, "_busy_cycles"}, 64'(busy_cnt), 64'd32);
    check({tag, "_done_count"}, 64'(ndone), 64'd1);
    check({tag, "_hold"}, 64'(hold_bad), 64'd0);
    check({tag, "_bcd"}, 64'(bcd), 64'(exp_bcd));
    check({tag, "_ovf"}, 64'(overflow), 64'(exp_ovf));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        vecs[$];
    logic [31:0] v;
    logic [31:0] prev;
    int          first;
    int          second;
    int          ndone;
    logic        hold_bad;

    // Reset held with start active and all-ones input.
    rst_n = 1'b0;
    start = 1'b1;
    bin   = 32'hFFFF_FFFF;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_done", 64'(done), 64'd0);
      check("rst_bcd", 64'(bcd), 64'd0);
      check("rst_ovf", 64'(overflow), 64'd0);
    end
    @(negedge clk);
    start = 1'b0;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      check("post_rst_idle_busy", 64'(busy), 64'd0);
      check("post_rst_idle_done", 64'(done), 64'd0);
    end

    // Directed vectors.
    vecs.push_back('{32'd12345678,  32'h12345678, 1'b0});
    vecs.push_back('{32'd99999999,  32'h99999999, 1'b0});
    vecs.push_back('{32'd100000000, 32'h00000000, 1'b1});
    vecs.push_back('{32'd0,         32'h00000000, 1'b0});
    vecs.push_back('{32'hFFFFFFFF,  32'h94967295, 1'b1});
    vecs.push_back('{32'd1,         32'h00000001, 1'b0});
    vecs.push_back('{32'd10,        32'h00000010, 1'b0});
    vecs.push_back('{32'd100000001, 32'h00000001, 1'b1});
    for (int i = 0; i < vecs.size(); i++)
      run_conv(vecs[i].v, $sformatf("vec%0d", i), vecs[i].exp_bcd, vecs[i].exp_ovf);

    // Random values against the decimal model.
    for (int i = 0; i < 20; i++) begin
      v = (i % 2 == 0) ? $urandom_range(0, 99999999) : $urandom;
      run_conv(v, $sformatf("rand%0d", i), model_bcd(64'(v)), 1'(64'(v) >= 64'd100000000));
    end

    // Ignored start/bin during conversion, then back-to-back via held start.
    @(negedge clk);
    bin   = 32'd42;
    start = 1'b1;
    @(posedge clk);
    #1;
    start    = 1'b0;
    bin      = 32'd7;
    prev     = bcd;
    first    = -1;
    second   = -1;
    ndone    = 0;
    hold_bad = 1'b0;
    for (int k = 1; k <= 80; k++) begin
      @(posedge clk);
      #1;
      if (done) begin
        ndone++;
        if (first < 0) begin
          first = k;
          check("b2b_first_bcd", 64'(bcd), 64'h42);
        end else if (second < 0) begin
          second = k;
          check("b2b_second_bcd", 64'(bcd), 64'h777);
          start = 1'b0;
        end
        prev = bcd;
      end else if (bcd !== prev) begin
        hold_bad = 1'b1;
      end
      if (k == 5 || k == 20) begin
        start = 1'b1;
        bin   = 32'd7;
      end else if (k == 6 || k == 21) begin
        start = 1'b0;
      end
      if (k == 30) begin
        start = 1'b1;
        bin   = 32'd777;
      end
      if (k == 33) bin = 32'd5;
    end
    check("b2b_first_latency", 64'(first), 64'd32);
    check("b2b_spacing", 64'(second - first), 64'd33);
    check("b2b_done_count", 64'(ndone), 64'd2);
    check("b2b_hold", 64'(hold_bad), 64'd0);

    // Asynchronous reset in the middle of a conversion.
    run_conv(32'd123, "pre_rst", 32'h00000123, 1'b0);
    @(negedge clk);
    bin   = 32'd999;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk);
      #1;
    end
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_bcd", 64'(bcd), 64'd0);
    check("midrst_ovf", 64'(overflow), 64'd0);
    check("midrst_done", 64'(done), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk);
      #1;
      if (done) ndone++;
    end
    check("midrst_no_done", 64'(ndone), 64'd0);
    check("midrst_idle", 64'(busy), 64'd0);
    run_conv(32'd456, "after_rst", 32'h00000456, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
